tictactoe_game: RTL and testbench

Sequential, parametrised tic-tac-toe game controller for an N×N board with K-in-a-row win rule. Accepts one move per handshake, enforces alternating turns starting with X, rejects illegal moves, and holds the registered board and win/draw outcome until a new game is started. Sits between the user-input front end (switch/button decode) and the display driver. Replaces purely combinational board checking with a stateful game engine.

---
 rtl/tictactoe_pkg.sv | 8 +
 rtl/tictactoe_if.sv | 42 ++++
 rtl/tictactoe_line_check.sv | 53 +++++
 rtl/tictactoe_game.sv | 141 ++++++++++++++
 tb/tb_tictactoe_game.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types and limits for the tic-tac-toe game engine.
package tictactoe_pkg;
  localparam int N_MAX = 8;
  localparam int K_MIN = 3;

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;
  typedef enum logic {PLAYER_X = 1'b0, PLAYER_O = 1'b1} player_t;
endpackage

// File: rtl/tictactoe_if.sv
// Move handshake and game-state bundle between the input front end and the engine.
// The undo pulse exists only when TTT_UNDO_EN is defined.
interface tictactoe_if #(parameter int N = 3) ();
  localparam int CW   = $clog2(N);
  localparam int CNTW = $clog2(N*N+1);

  logic            start;
  logic            move_valid;
  logic            move_ready;
  logic [CW-1:0]   move_row;
  logic [CW-1:0]   move_col;
`ifdef TTT_UNDO_EN
  logic            undo;
`endif
  logic [N*N-1:0]  board_x;
  logic [N*N-1:0]  board_o;
  logic            turn_o;
  logic            illegal;
  logic            win_x;
  logic            win_o;
  logic            draw;
  logic            game_over;
  logic [CNTW-1:0] move_count;

  modport master (
    output start, move_valid, move_row, move_col,
`ifdef TTT_UNDO_EN
    output undo,
`endif
    input  move_ready, board_x, board_o, turn_o, illegal,
    input  win_x, win_o, draw, game_over, move_count
  );

  modport slave (
    input  start, move_valid, move_row, move_col,
`ifdef TTT_UNDO_EN
    input  undo,
`endif
    output move_ready, board_x, board_o, turn_o, illegal,
    output win_x, win_o, draw, game_over, move_count
  );
endinterface

// File: rtl/tictactoe_line_check.sv
// Combinational K-in-a-row detector restricted to the four lines through one cell.
// Every K-long window on the board is a constant mask; a window counts only if it
// lies on the row, column, diagonal or anti-diagonal of (row, col).
module tictactoe_line_check #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [N*N-1:0]         board,
  input  logic [$clog2(N)-1:0]   row,
  input  logic [$clog2(N)-1:0]   col,
  output logic                   win
);
  localparam int NN = N*N;

  function automatic logic [NN-1:0] wmask(int r, int c, int dr, int dc);
    logic [NN-1:0] m;
    m = '0;
    for (int k = 0; k < K; k++) m = m | (NN'(1) << ((r + k*dr)*N + c + k*dc));
    return m;
  endfunction

  // A window's start cell shares the line invariant of every cell in it.
  function automatic logic on_line(int d, int r, int c, int pr, int pc);
    case (d)
      0:       return r == pr;
      1:       return c == pc;
      2:       return (r - c) == (pr - pc);
      default: return (r + c) == (pr + pc);
    endcase
  endfunction

  logic [4*NN-1:0] hit;

  for (genvar d = 0; d < 4; d++) begin : g_dir
    localparam int DR = (d == 0) ? 0 : 1;
    localparam int DC = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
    for (genvar r = 0; r < N; r++) begin : g_r
      for (genvar c = 0; c < N; c++) begin : g_c
        localparam int ER = r + (K-1)*DR;
        localparam int EC = c + (K-1)*DC;
        if (ER < N && EC >= 0 && EC < N) begin : g_fit
          localparam logic [NN-1:0] M = wmask(r, c, DR, DC);
          assign hit[d*NN + r*N + c] = on_line(d, r, c, int'(row), int'(col)) &&
                                       ((board & M) == M);
        end else begin : g_nofit
          assign hit[d*NN + r*N + c] = 1'b0;
        end
      end
    end
  end

  assign win = |hit;
endmodule

// File: rtl/tictactoe_game.sv
// Stateful N x N, K-in-a-row tic-tac-toe engine: one move per two cycles,
// illegal-move rejection, sticky outcome. TTT_UNDO_EN adds a one-deep undo.
module tictactoe_game
  import tictactoe_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input logic       clk,
  input logic       rst_n,
  tictactoe_if.slave bus
);
  localparam int NN   = N*N;
  localparam int CW   = $clog2(N);
  localparam int CNTW = $clog2(NN+1);

  state_t          st;
  player_t         turn;
  logic [NN-1:0]   bx, bo;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   lrow, lcol;
  logic            rdy, ill, wx, wo, drw, go;
`ifdef TTT_UNDO_EN
  logic [NN-1:0]   rec;
  logic            rec_v;
`endif

  logic [NN-1:0]   sel;
  logic            legal, line_win;

  assign sel   = NN'(1) << (int'(bus.move_row)*N + int'(bus.move_col));
  assign legal = (int'(bus.move_row) < N) && (int'(bus.move_col) < N) &&
                 (((bx | bo) & sel) == '0);

  // Only the player who just moved can have completed a line.
  tictactoe_line_check #(.N(N), .K(K)) u_chk (
    .board (turn == PLAYER_O ? bo : bx),
    .row   (lrow),
    .col   (lcol),
    .win   (line_win)
  );

  // Game FSM; start overrides everything, including an in-flight check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      turn <= PLAYER_X;
      bx   <= '0;
      bo   <= '0;
      cnt  <= '0;
      lrow <= '0;
      lcol <= '0;
      rdy  <= 1'b0;
      ill  <= 1'b0;
      wx   <= 1'b0;
      wo   <= 1'b0;
      drw  <= 1'b0;
      go   <= 1'b0;
`ifdef TTT_UNDO_EN
      rec   <= '0;
      rec_v <= 1'b0;
`endif
    end else begin
      ill <= 1'b0;
      if (bus.start) begin
        st   <= PLAY;
        turn <= PLAYER_X;
        bx   <= '0;
        bo   <= '0;
        cnt  <= '0;
        rdy  <= 1'b1;
        wx   <= 1'b0;
        wo   <= 1'b0;
        drw  <= 1'b0;
        go   <= 1'b0;
`ifdef TTT_UNDO_EN
        rec_v <= 1'b0;
`endif
      end else begin
        case (st)
          PLAY: begin
            if (bus.move_valid) begin
              if (legal) begin
                if (turn == PLAYER_O) bo <= bo | sel;
                else                  bx <= bx | sel;
                cnt  <= cnt + CNTW'(1);
                lrow <= bus.move_row;
                lcol <= bus.move_col;
                rdy  <= 1'b0;
                st   <= CHECK;
`ifdef TTT_UNDO_EN
                rec   <= sel;
                rec_v <= 1'b1;
`endif
              end else begin
                ill <= 1'b1;
              end
            end
`ifdef TTT_UNDO_EN
            else if (bus.undo && rec_v && cnt != '0) begin
              bx    <= bx & ~rec;
              bo    <= bo & ~rec;
              cnt   <= cnt - CNTW'(1);
              turn  <= (turn == PLAYER_O) ? PLAYER_X : PLAYER_O;
              rec_v <= 1'b0;
            end
`endif
          end
          CHECK: begin
            if (line_win) begin
              if (turn == PLAYER_O) wo <= 1'b1;
              else                  wx <= 1'b1;
              go <= 1'b1;
              st <= OVER;
            end else if (cnt == CNTW'(NN)) begin
              drw <= 1'b1;
              go  <= 1'b1;
              st  <= OVER;
            end else begin
              turn <= (turn == PLAYER_O) ? PLAYER_X : PLAYER_O;
              rdy  <= 1'b1;
              st   <= PLAY;
            end
          end
          default: ; // IDLE and OVER wait for start
        endcase
      end
    end
  end

  assign bus.move_ready = rdy;
  assign bus.board_x    = bx;
  assign bus.board_o    = bo;
  assign bus.turn_o     = turn;
  assign bus.illegal    = ill;
  assign bus.win_x      = wx;
  assign bus.win_o      = wo;
  assign bus.draw       = drw;
  assign bus.game_over  = go;
  assign bus.move_count = cnt;
endmodule

// File: tb/tb_tictactoe_game.sv
// Directed bench for tictactoe_game: 3x3/K=3 and 5x5/K=4 instances.
// Undo steps run only when TTT_UNDO_EN is defined.
module tb_tictactoe_game;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  tictactoe_if #(.N(3)) if3 ();
  tictactoe_if #(.N(5)) if5 ();

  tictactoe_game #(.N(3), .K(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  tictactoe_game #(.N(5), .K(4)) u5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start3();
    if3.start = 1'b1; tick(); if3.start = 1'b0;
  endtask

  task automatic start5();
    if5.start = 1'b1; tick(); if5.start = 1'b0;
  endtask

  // Handshake, then wait out the CHECK cycle.
  task automatic play3(input int r, input int c);
    if3.move_row = 2'(r); if3.move_col = 2'(c); if3.move_valid = 1'b1;
    tick(); if3.move_valid = 1'b0; tick();
  endtask

  task automatic play5(input int r, input int c);
    if5.move_row = 3'(r); if5.move_col = 3'(c); if5.move_valid = 1'b1;
    tick(); if5.move_valid = 1'b0; tick();
  endtask

  initial begin
    if3.start = 0; if3.move_valid = 0; if3.move_row = 0; if3.move_col = 0;
    if5.start = 0; if5.move_valid = 0; if5.move_row = 0; if5.move_col = 0;
`ifdef TTT_UNDO_EN
    if3.undo = 0; if5.undo = 0;
`endif
    #3;
    chk("rst_ready", 32'(if3.move_ready), 32'd0);
    chk("rst_bx", 32'(if3.board_x), 32'd0);
    chk("rst_cnt", 32'(if3.move_count), 32'd0);
    chk("rst_flags", {28'd0, if3.win_x, if3.win_o, if3.draw, if3.game_over}, 32'd0);
    chk("rst_turn", 32'(if3.turn_o), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // IDLE ignores moves
    play3(0, 0);
    chk("idle_bx", 32'(if3.board_x), 32'd0);
    chk("idle_ready", 32'(if3.move_ready), 32'd0);

    // X wins on the top row
    start3();
    chk("start_ready", 32'(if3.move_ready), 32'd1);
    if3.move_row = 0; if3.move_col = 0; if3.move_valid = 1'b1;
    tick(); if3.move_valid = 1'b0;
    chk("chk_ready", 32'(if3.move_ready), 32'd0);
    chk("chk_bx", 32'(if3.board_x), 32'h001);
    chk("chk_cnt", 32'(if3.move_count), 32'd1);
    tick();
    chk("flip_turn", 32'(if3.turn_o), 32'd1);
    chk("flip_ready", 32'(if3.move_ready), 32'd1);
    play3(1, 0); play3(0, 1); play3(1, 1); play3(0, 2);
    chk("row_winx", 32'(if3.win_x), 32'd1);
    chk("row_wino", 32'(if3.win_o), 32'd0);
    chk("row_ready", 32'(if3.move_ready), 32'd0);
    chk("row_bx", 32'(if3.board_x), 32'h007);
    chk("row_bo", 32'(if3.board_o), 32'h018);
    chk("row_over", 32'(if3.game_over), 32'd1);

    // illegal moves
    start3();
    play3(1, 1);
    if3.move_row = 1; if3.move_col = 1; if3.move_valid = 1'b1;
    tick(); if3.move_valid = 1'b0;
    chk("occ_illegal", 32'(if3.illegal), 32'd1);
    chk("occ_ready", 32'(if3.move_ready), 32'd1);
    tick();
    chk("occ_pulse", 32'(if3.illegal), 32'd0);
    chk("occ_turn", 32'(if3.turn_o), 32'd1);
    chk("occ_bo", 32'(if3.board_o), 32'd0);
    chk("occ_cnt", 32'(if3.move_count), 32'd1);
    if3.move_row = 3; if3.move_col = 0; if3.move_valid = 1'b1;
    tick(); if3.move_valid = 1'b0;
    chk("oor_illegal", 32'(if3.illegal), 32'd1);
    tick();

    // start beats a simultaneous move
    if3.start = 1'b1; if3.move_row = 0; if3.move_col = 0; if3.move_valid = 1'b1;
    tick(); if3.start = 1'b0; if3.move_valid = 1'b0;
    chk("stmv_bx", 32'(if3.board_x), 32'd0);
    chk("stmv_cnt", 32'(if3.move_count), 32'd0);
    chk("stmv_turn", 32'(if3.turn_o), 32'd0);
    chk("stmv_ready", 32'(if3.move_ready), 32'd1);

`ifdef TTT_UNDO_EN
    play3(0, 0);
    if3.undo = 1'b1; tick(); if3.undo = 1'b0;
    chk("undo_bx", 32'(if3.board_x), 32'd0);
    chk("undo_cnt", 32'(if3.move_count), 32'd0);
    chk("undo_turn", 32'(if3.turn_o), 32'd0);
    if3.undo = 1'b1; tick(); if3.undo = 1'b0;
    chk("undo2_cnt", 32'(if3.move_count), 32'd0);
    chk("undo2_turn", 32'(if3.turn_o), 32'd0);
`endif

    // full board, no line: draw
    start3();
    play3(0, 0); play3(0, 1); play3(0, 2); play3(1, 1); play3(1, 0);
    play3(1, 2); play3(2, 1); play3(2, 0); play3(2, 2);
    chk("draw_flag", 32'(if3.draw), 32'd1);
    chk("draw_winx", 32'(if3.win_x), 32'd0);
    chk("draw_cnt", 32'(if3.move_count), 32'd9);
    chk("draw_bx", 32'(if3.board_x), 32'h18D);
    chk("draw_bo", 32'(if3.board_o), 32'h072);

    // ninth move completes the diagonal: win beats draw
    start3();
    play3(0, 0); play3(0, 1); play3(0, 2); play3(1, 0); play3(1, 1);
    play3(1, 2); play3(2, 1); play3(2, 0); play3(2, 2);
    chk("last_winx", 32'(if3.win_x), 32'd1);
    chk("last_draw", 32'(if3.draw), 32'd0);
    chk("last_cnt", 32'(if3.move_count), 32'd9);

    // 5x5, K=4 anti-diagonal
    start5();
    play5(0, 4); play5(0, 0); play5(1, 3); play5(1, 0); play5(2, 2); play5(2, 0);
    chk("k4_three", 32'(if5.win_x), 32'd0);
    chk("k4_ready", 32'(if5.move_ready), 32'd1);
    play5(3, 1);
    chk("k4_winx", 32'(if5.win_x), 32'd1);
    chk("k4_bx", 32'(if5.board_x), 32'h0011110);
    start5();
    if5.move_row = 5; if5.move_col = 0; if5.move_valid = 1'b1;
    tick(); if5.move_valid = 1'b0;
    chk("k4_oor", 32'(if5.illegal), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
